// File: rtl/ram_ctrl.sv
// ram_ctrl: single-cycle data-memory responder -- word RAM plus a 4-register MMIO window
// (GPIO, STATUS, TIMER, ACCCNT). Define RAM_CTRL_TIMER_EN to build the TIMER at MMIO +2.
module ram_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_r_en,
    input  logic        ram_w_en,
    input  logic [31:0] ram_wr_addr,
    input  logic [31:0] ram_w_data,
    output logic [31:0] ram_r_data,
    output logic [31:0] gpio_out,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] REG_GPIO   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TIMER  = 2'd2;
    localparam logic [1:0] REG_ACCCNT = 2'd3;

    logic [31:0] mem [DEPTH];

    logic [31:0] ram_r_data_q, ram_r_data_d;
    logic [31:0] gpio_q,       gpio_d;
    logic [2:0]  status_q,     status_d;
    logic [31:0] acccnt_q,     acccnt_d;

    // ------------------------------------------------------------------
    // Address decode on the full 32-bit word address
    // ------------------------------------------------------------------
    logic              ram_hit;
    logic              mmio_hit;
    logic [31:0]       mmio_off;
    logic [1:0]        reg_sel;
    logic [ADDR_W-1:0] ram_idx;
    logic              gpio_hit, status_hit, timer_hit, acccnt_hit;
    logic              mapped;

    assign ram_hit  = (ram_wr_addr >> ADDR_W) == 32'd0;
    assign ram_idx  = ram_wr_addr[ADDR_W-1:0];
    // Subtracting the base keeps the window test correct for any base alignment.
    assign mmio_off = ram_wr_addr - MMIO_BASE;
    assign mmio_hit = !ram_hit && (mmio_off < 32'd4);
    assign reg_sel  = mmio_off[1:0];

    assign gpio_hit   = mmio_hit && (reg_sel == REG_GPIO);
    assign status_hit = mmio_hit && (reg_sel == REG_STATUS);
    assign acccnt_hit = mmio_hit && (reg_sel == REG_ACCCNT);
`ifdef RAM_CTRL_TIMER_EN
    assign timer_hit  = mmio_hit && (reg_sel == REG_TIMER);
`else
    assign timer_hit  = 1'b0;
`endif

    assign mapped = ram_hit || gpio_hit || status_hit || timer_hit || acccnt_hit;

    // ------------------------------------------------------------------
    // Optional free-running timer
    // ------------------------------------------------------------------
`ifdef RAM_CTRL_TIMER_EN
    logic [31:0] timer_q, timer_d;

    // A write replaces this edge's increment; counting resumes from the loaded value.
    assign timer_d = (ram_w_en && timer_hit) ? ram_w_data : timer_q + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux: all sources are pre-edge values, so reads are read-first
    // ------------------------------------------------------------------
    logic [31:0] rd_word;

    always_comb begin
        // NOTE: default assignment first so no path leaves rd_word unassigned (no latch).
        rd_word = 32'd0;
        if (ram_hit) begin
            rd_word = mem[ram_idx];
        end else if (gpio_hit) begin
            rd_word = gpio_q;
        end else if (status_hit) begin
            rd_word = {29'd0, status_q};
        end else if (acccnt_hit) begin
            rd_word = acccnt_q;
        end
`ifdef RAM_CTRL_TIMER_EN
        else if (timer_hit) begin
            rd_word = timer_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic for registers
    // ------------------------------------------------------------------
    logic [2:0] status_clr;
    logic [2:0] status_set;

    always_comb begin
        ram_r_data_d = ram_r_en ? rd_word : ram_r_data_q;
        gpio_d       = (ram_w_en && gpio_hit) ? ram_w_data : gpio_q;
        acccnt_d     = (ram_r_en || ram_w_en) ? acccnt_q + 32'd1 : acccnt_q;

        status_clr    = (ram_w_en && status_hit) ? ram_w_data[2:0] : 3'd0;
        status_set[0] = ram_r_en && !mapped;
        status_set[1] = ram_w_en && !mapped;
        status_set[2] = ram_r_en && ram_w_en;
        // New error events win over a same-edge write-1-to-clear.
        status_d      = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_r_data_q <= 32'd0;
            gpio_q       <= 32'd0;
            status_q     <= 3'd0;
            acccnt_q     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ram_r_data_q <= ram_r_data_d;
            gpio_q       <= gpio_d;
            status_q     <= status_d;
            acccnt_q     <= acccnt_d;
        end
    end

    // NOTE: RAM array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (rst && ram_w_en && ram_hit) begin
            mem[ram_idx] <= ram_w_data;
        end
    end

    assign ram_r_data = ram_r_data_q;
    assign gpio_out   = gpio_q;
    assign err        = |status_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a stimulus process drives directed and random requests and
// pushes expected outputs from a behavioural model; a monitor pops and compares after each posedge.
module tb_ram_ctrl;

    localparam int unsigned ADDR_W    = 8;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
`ifdef RAM_CTRL_TIMER_EN
    localparam bit TIMER_EXISTS = 1'b1;
`else
    localparam bit TIMER_EXISTS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_r_en = 1'b0;
    logic        ram_w_en = 1'b0;
    logic [31:0] ram_wr_addr = 32'd0;
    logic [31:0] ram_w_data = 32'd0;
    logic [31:0] ram_r_data;
    logic [31:0] gpio_out;
    logic        err;

    ram_ctrl #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_r_en    (ram_r_en),
        .ram_w_en    (ram_w_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_w_data  (ram_w_data),
        .ram_r_data  (ram_r_data),
        .gpio_out    (gpio_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] gpio;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural reference state
    logic [31:0] m_mem [256];
    logic [31:0] m_rdata, m_gpio, m_timer, m_acc;
    logic [2:0]  m_status;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdata  = 32'd0;
        m_gpio   = 32'd0;
        m_timer  = 32'd0;
        m_acc    = 32'd0;
        m_status = 3'd0;
    endtask

    // One clock edge of the register map, evaluated from its architectural rules.
    task automatic model_step(input bit r, input bit w, input logic [31:0] addr,
                              input logic [31:0] data);
        longint      a;
        bit          is_ram, is_reg, is_mapped;
        int          sel;
        logic [31:0] rd, nxt_timer;
        logic [2:0]  st;
        exp_t        e;

        a         = longint'(addr);
        is_ram    = a < 256;
        is_reg    = !is_ram && a >= longint'(MMIO_BASE) && a < longint'(MMIO_BASE) + 4;
        sel       = is_reg ? int'(a - longint'(MMIO_BASE)) : -1;
        is_mapped = is_ram || (is_reg && (sel != 2 || TIMER_EXISTS));

        rd = 32'd0;
        if (is_ram) rd = m_mem[addr[7:0]];
        else if (sel == 0) rd = m_gpio;
        else if (sel == 1) rd = {29'd0, m_status};
        else if (sel == 2) rd = TIMER_EXISTS ? m_timer : 32'd0;
        else if (sel == 3) rd = m_acc;

        st = m_status;
        if (w && sel == 1) st = st & ~data[2:0];
        if (r && !is_mapped) st[0] = 1'b1;
        if (w && !is_mapped) st[1] = 1'b1;
        if (r && w) st[2] = 1'b1;

        nxt_timer = m_timer + 32'd1;
        if (w) begin
            if (is_ram) m_mem[addr[7:0]] = data;
            else if (sel == 0) m_gpio = data;
            else if (sel == 2 && TIMER_EXISTS) nxt_timer = data;
        end
        if (r) m_rdata = rd;
        if (r || w) m_acc = m_acc + 32'd1;
        m_status = st;
        m_timer  = nxt_timer;

        e.rdata = m_rdata;
        e.gpio  = m_gpio;
        e.err   = |m_status;
        exp_q.push_back(e);
    endtask

    task automatic do_cycle(input bit r, input bit w, input logic [31:0] addr,
                            input logic [31:0] data);
        @(negedge clk);
        ram_r_en    = r;
        ram_w_en    = w;
        ram_wr_addr = addr;
        ram_w_data  = data;
        model_step(r, w, addr, data);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned pick;
        logic [31:0] unm [5];
        unm[0] = 32'h0000_0100;
        unm[1] = 32'h0000_1000;
        unm[2] = MMIO_BASE - 32'd1;
        unm[3] = MMIO_BASE + 32'd4;
        unm[4] = 32'h8000_0000 | $urandom_range(32'h0FFF_FFFF, 0);
        pick = $urandom_range(99, 0);
        if (pick < 60) return 32'($urandom_range(15, 0));
        if (pick < 85) return MMIO_BASE + 32'($urandom_range(3, 0));
        return unm[$urandom_range(4, 0)];
    endfunction

    // Monitor: one expected entry per non-reset posedge carrying stimulus.
    initial begin
        bit   in_rst;
        exp_t e;
        forever begin
            @(posedge clk);
            in_rst = !rst;
            #1;
            if (!in_rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ram_r_data", ram_r_data, e.rdata);
                check("gpio_out", gpio_out, e.gpio);
                check("err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset ram_r_data", ram_r_data, 32'd0);
        check("reset gpio_out", gpio_out, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 32'(i), $urandom);

        // RAM write then read, then ACCCNT
        do_cycle(1'b0, 1'b1, 32'd5, 32'h1234_5678);
        do_cycle(1'b1, 1'b0, 32'd5, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd3, 32'd0);

        // GPIO
        do_cycle(1'b0, 1'b1, MMIO_BASE, 32'hA5A5_0000);
        do_cycle(1'b1, 1'b0, MMIO_BASE, 32'd0);

        // Unmapped read, STATUS read, W1C clear
        do_cycle(1'b1, 1'b0, 32'h0000_1000, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd1, 32'd0);
        do_cycle(1'b0, 1'b1, MMIO_BASE + 32'd1, 32'd1);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd1, 32'd0);

        // Same-edge read and write
        do_cycle(1'b0, 1'b1, 32'd7, 32'h0000_0011);
        do_cycle(1'b1, 1'b1, 32'd7, 32'h0000_0022);
        do_cycle(1'b1, 1'b0, 32'd7, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd1, 32'd0);
        do_cycle(1'b0, 1'b1, MMIO_BASE + 32'd1, 32'd7);

        // TIMER load and wrap (unmapped when the timer is not built)
        do_cycle(1'b0, 1'b1, MMIO_BASE + 32'd2, 32'hFFFF_FFFE);
        do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd2, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd2, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd1, 32'd0);
        do_cycle(1'b0, 1'b1, MMIO_BASE + 32'd1, 32'd7);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned kind;
            kind = $urandom_range(9, 0);
            do_cycle(kind < 5 || kind == 9, kind >= 5, rand_addr(), $urandom);
        end

        // Reset asserted in the middle of a read
        do_cycle(1'b0, 1'b1, 32'd5, 32'h1234_5678);
        do_cycle(1'b0, 1'b1, MMIO_BASE, 32'h0000_00FF);
        @(negedge clk);
        ram_r_en    = 1'b1;
        ram_w_en    = 1'b0;
        ram_wr_addr = 32'd5;
        #2 rst = 1'b0;
        #1;
        check("mid-read reset ram_r_data", ram_r_data, 32'd0);
        check("mid-read reset gpio_out", gpio_out, 32'd0);
        check("mid-read reset err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        ram_r_en = 1'b0;
        rst      = 1'b1;
        model_reset();

        do_cycle(1'b1, 1'b0, MMIO_BASE + 32'd3, 32'd0);
        do_cycle(1'b1, 1'b0, 32'd5, 32'd0);
        do_cycle(1'b1, 1'b0, MMIO_BASE, 32'd0);
        do_cycle(1'b0, 1'b0, 32'd0, 32'd0);

        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
